bus_capture: RTL and testbench
==============================

# bus_capture

Front-end stage of the bus-snooping cache. Samples the 65816-style multiplexed CPU bus (16-bit `a`, bank byte on `d` while `phi2` is low) in the `fpga` clock domain and rebuilds one 24-bit address per accepted `phi2` cycle. Addresses queue in a small first-word-fall-through FIFO with a valid/ready handshake, so the downstream cache lookup can stall without losing bus cycles. Also reports the measured `phi2` period.

## Interface
- `DEPTH`, 4: FIFO entries; power of 2, ≥2.
- `MIN_LOW`, 2: minimum consecutive synchronized-low `fpga` cycles of `phi2` before a rise counts as a bus cycle (glitch filter).
- `fpga`  in  1  system clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- `phi2`  in  1  CPU phase-2 clock, asynchronous to `fpga`.
- `a`  in  16  CPU address bus, asynchronous.
- `d`  in  8  CPU data bus; carries the bank byte while `phi2` is low.
- `addr`  out  24  FIFO head: {bank, a}.
- `addr_valid`  out  1  FIFO non-empty.
- `addr_ready`  in  1  consumer accepts head this cycle.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `period`  out  16  `fpga` cycles between the last two accepted edges, saturating.
- `overflow`  out  1  sticky; set when a capture is dropped because the FIFO is full.
- `clr_ovf`  in  1  synchronous clear of `overflow`.

## Operation
- Synchronizer: `phi2`, `a`, `d` each pass through identical 2-flop stages (s1, s2), then a third stage s3, so all three stay aligned.
- Low filter: `low_cnt` counts consecutive s2 `phi2`==0 cycles and saturates at `MIN_LOW`. It clears when s2 `phi2`==1.
- Accepted edge: s2 `phi2`==1 and s3 `phi2`==0 and `low_cnt`==`MIN_LOW`. A rise after a shorter low is ignored and produces no capture or period update.
- Capture on an accepted edge: push {s3 `d`, s3 `a`}, i.e. the last sample taken while `phi2` was low.
- FIFO:
  - Circular buffer, pointers one bit wider than the index.
  - `addr` is combinational from the head entry; `addr` = 0 when empty.
  - Pop when `addr_valid` and `addr_ready`.
  - Push while full with no pop: the entry is dropped and `overflow` is set.
  - Push and pop in the same cycle while full: both happen, `level` stays at `DEPTH`, no overflow.
  - Pop while empty: ignored.
- Period:
  - A 16-bit counter increments every cycle and saturates at 0xFFFF.
  - On an accepted edge, `period` is loaded with counter+1 (saturated) and the counter restarts at 0.
  - The first edge after reset reports the count since reset release.
- `overflow`: set has priority over `clr_ovf` in the same cycle.
- Pointer arithmetic wraps modulo 2·`DEPTH`. `level` = wptr − rptr.

## Timing
- Reset values: `addr`=0x000000, `addr_valid`=0, `level`=0, `period`=0, `overflow`=0. Sync stages and s3 reset to 0. `low_cnt` resets to 0, so a full `MIN_LOW` low must be seen after reset before the first capture.
- Reset asserted mid-operation: all state clears immediately, including FIFO contents.
- Latency: edge k is the first `fpga` edge at which s1 samples `phi2`=1. s2=1 at k+1; the accepted edge is detected during cycle k+1; the push happens at k+2. With the FIFO empty, `addr_valid` goes high after edge k+2 (3 cycles).
- Maximum capture rate: one per `MIN_LOW`+1 cycles. Drain rate: one pop per cycle.
- Data stability: `a`/`d` are assumed stable for ≥2 `fpga` cycles before `phi2` rises. Captured data is whatever s3 holds at that point; no further qualification.

## Test plan
- Reset, then hold `phi2`=0 for 10 cycles with `d`=0x12 and `a`=0x3456, then raise `phi2`, `addr_ready`=0 → `addr_valid` rises exactly 3 cycles after the first sampling edge; `addr`=0x123456; `level`=1.
- Low glitch: `phi2` low for 1 synchronized cycle then high (`MIN_LOW`=2) → no push; `level` and `period` unchanged.
- Fill: 5 accepted cycles with addresses 0x000000, 0x28A492, 0x514924, 0x79EDB6, 0xA29248 while `addr_ready`=0 → `level`=4, `overflow`=1, head=0x000000. Draining yields the first four addresses in order; the fifth is lost.
- Simultaneous push and pop with FIFO full, `addr_ready`=1 on the capture cycle → `level` stays 4, `overflow` stays 0, head advances by one.
- Period: accepted edges spaced 40 `fpga` cycles apart → `period`=40 after the second edge. An edge spacing above 65535 cycles → `period`=0xFFFF.
- `reset_n` pulsed low with `level`=3 and `overflow`=1 → all outputs return to reset values asynchronously. The next capture requires 2 low cycles after release.

Source files
------------

// File: rtl/bus_capture.sv
// bus_capture: synchronizes the multiplexed 65816 bus into the fpga domain,
// rebuilds one 24-bit {bank, addr} per qualified phi2 rise, queues it in a
// small first-word-fall-through FIFO and measures the phi2 period.
module bus_capture #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MIN_LOW = 2
) (
  input  logic                       fpga,
  input  logic                       reset_n,
  input  logic                       phi2,
  input  logic [15:0]                a,
  input  logic [7:0]                 d,
  output logic [23:0]                addr,
  output logic                       addr_valid,
  input  logic                       addr_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                period,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(MIN_LOW + 1);
  localparam int unsigned BW = 24;

  // Synchronizer stages; phi2 and the {d, a} bus move through identical
  // stages so the captured word always belongs to the sampled phi2 phase.
  logic          phi2_s1_q, phi2_s2_q, phi2_s3_q;
  logic [BW-1:0] bus_s1_q, bus_s2_q, bus_s3_q;

  // Low-phase qualification.
  logic [CW-1:0] low_cnt_q, low_cnt_d;
  logic          edge_acc;

  // FIFO storage and pointers (one extra bit to tell full from empty).
  logic [BW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] level_q, level_d;
  logic          valid_q, valid_d;
  logic          fifo_full;
  logic          do_pop;
  logic          do_push;
  logic          do_drop;

  // Period measurement.
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   cnt_inc;
  logic [15:0]   period_q, period_d;

  // Sticky overflow.
  logic          ovf_q, ovf_d;

  // Three-stage sampling of phi2 and the multiplexed bus.
  always_ff @(posedge fpga or negedge reset_n) begin
    if (!reset_n) begin
      phi2_s1_q <= 1'b0;
      phi2_s2_q <= 1'b0;
      phi2_s3_q <= 1'b0;
      bus_s1_q  <= '0;
      bus_s2_q  <= '0;
      bus_s3_q  <= '0;
    end else begin
      phi2_s1_q <= phi2;
      phi2_s2_q <= phi2_s1_q;
      phi2_s3_q <= phi2_s2_q;
      bus_s1_q  <= {d, a};
      bus_s2_q  <= bus_s1_q;
      bus_s3_q  <= bus_s2_q;
    end
  end

  // Count consecutive synchronized-low cycles, saturating at MIN_LOW.
  always_comb begin
    low_cnt_d = low_cnt_q;
    if (phi2_s2_q) begin
      low_cnt_d = '0;
    end else if (low_cnt_q != CW'(MIN_LOW)) begin
      low_cnt_d = low_cnt_q + CW'(1);
    end
  end

  // A rise only counts after a long enough low phase (glitch filter).
  always_comb begin
    edge_acc = phi2_s2_q & ~phi2_s3_q & (low_cnt_q == CW'(MIN_LOW));
  end

  // Low-phase counter register.
  always_ff @(posedge fpga or negedge reset_n) begin
    if (!reset_n) begin
      low_cnt_q <= '0;
    end else begin
      low_cnt_q <= low_cnt_d;
    end
  end

  // FIFO control: pop on handshake, push unless full without a pop.
  always_comb begin
    fifo_full = (level_q == PW'(DEPTH));
    do_pop    = valid_q & addr_ready;
    do_push   = edge_acc & (~fifo_full | do_pop);
    do_drop   = edge_acc & fifo_full & ~do_pop;
    wptr_d    = wptr_q + PW'(do_push);
    rptr_d    = rptr_q + PW'(do_pop);
    level_d   = wptr_d - rptr_d;
    valid_d   = (wptr_d != rptr_d);
  end

  // FIFO pointers, occupancy and non-empty flag.
  always_ff @(posedge fpga or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      valid_q <= valid_d;
    end
  end

  // FIFO storage; cleared on reset so stale entries never reappear.
  always_ff @(posedge fpga or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= bus_s3_q;
    end
  end

  // Head of queue is presented directly; zero while empty.
  always_comb begin
    addr = '0;
    if (valid_q) begin
      addr = mem_q[rptr_q[AW-1:0]];
    end
  end

  // Free-running saturating counter; reloads period on each accepted edge.
  always_comb begin
    cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    cnt_d    = cnt_inc;
    period_d = period_q;
    if (edge_acc) begin
      period_d = cnt_inc;
      cnt_d    = '0;
    end
  end

  // Period counter and reported period.
  always_ff @(posedge fpga or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      period_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

  // Sticky overflow: a dropped capture wins over a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (do_drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // Overflow flag register.
  always_ff @(posedge fpga or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign addr_valid = valid_q;
  assign level      = level_q;
  assign period     = period_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_bus_capture.sv
// Bench for bus_capture: directed scenarios plus randomized bus activity,
// compared every cycle against a sample-history / queue reference model.
module tb_bus_capture;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned MIN_LOW = 2;

  logic        fpga;
  logic        reset_n;
  logic        phi2;
  logic [15:0] a;
  logic [7:0]  d;
  logic [23:0] addr;
  logic        addr_valid;
  logic        addr_ready;
  logic [2:0]  level;
  logic [15:0] period;
  logic        overflow;
  logic        clr_ovf;

  int checks = 0;
  int errors = 0;
  bit model_on = 0;

  bus_capture #(.DEPTH(DEPTH), .MIN_LOW(MIN_LOW)) dut (
    .fpga       (fpga),
    .reset_n    (reset_n),
    .phi2       (phi2),
    .a          (a),
    .d          (d),
    .addr       (addr),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .level      (level),
    .period     (period),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  initial fpga = 1'b0;
  always #5 fpga = ~fpga;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history of the values seen at each fpga edge, plus the
  // queue contents, the cycles since the last accepted rise and the flag.
  typedef struct {
    bit          p;
    logic [23:0] ad;
    int          zrun;
  } smp_t;

  smp_t        hist[$];
  logic [23:0] mq[$];
  int          since;
  logic [15:0] m_period;
  bit          m_ovf;

  task automatic model_reset();
    smp_t s;
    hist.delete();
    mq.delete();
    // Sentinel high sample, then the two reset-zero stages counted as low.
    s.p = 1'b1; s.ad = '0; s.zrun = 0; hist.push_back(s);
    s.p = 1'b0; s.ad = '0; s.zrun = 1; hist.push_back(s);
    s.p = 1'b0; s.ad = '0; s.zrun = 2; hist.push_back(s);
    since    = 0;
    m_period = '0;
    m_ovf    = 1'b0;
  endtask

  // A rise sampled at edge m-2 after a low run ending at edge m-3 lands in
  // the queue at edge m, carrying the bus word sampled at edge m-3.
  always @(posedge fpga or negedge reset_n) begin
    smp_t s;
    int   n;
    bit   acc, pop, full;
    if (!reset_n) begin
      model_reset();
    end else if (model_on) begin
      n     = hist.size();
      since = since + 1;
      acc   = hist[n-2].p && !hist[n-3].p && (hist[n-3].zrun >= int'(MIN_LOW));
      pop   = (mq.size() > 0) && addr_ready;
      full  = (mq.size() == int'(DEPTH));
      if (pop) void'(mq.pop_front());
      if (acc) begin
        m_period = (since > 65535) ? 16'hFFFF : 16'(since);
        since    = 0;
        if (!(full && !pop)) mq.push_back(hist[n-3].ad);
      end
      if (acc && full && !pop) m_ovf = 1'b1;
      else if (clr_ovf)        m_ovf = 1'b0;
      s.p    = phi2;
      s.ad   = {d, a};
      s.zrun = phi2 ? 0 : ((hist[n-1].zrun < 1000) ? hist[n-1].zrun + 1 : 1000);
      hist.push_back(s);
      if (hist.size() > 4) void'(hist.pop_front());
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge fpga) begin
    if (model_on) begin
      check("addr",       {8'h0, addr},        (mq.size() > 0) ? {8'h0, mq[0]} : 32'h0);
      check("addr_valid", {31'h0, addr_valid}, {31'h0, (mq.size() > 0)});
      check("level",      {29'h0, level},      32'(mq.size()));
      check("period",     {16'h0, period},     {16'h0, m_period});
      check("overflow",   {31'h0, overflow},   {31'h0, m_ovf});
    end
  end

  task automatic cyc(input bit p, input logic [23:0] ad, input bit rdy, input bit clr);
    phi2       = p;
    d          = ad[23:16];
    a          = ad[15:0];
    addr_ready = rdy;
    clr_ovf    = clr;
    @(negedge fpga);
  endtask

  // Low 3 cycles, then high; the push lands on the 6th call.
  task automatic capture(input logic [23:0] ad, input bit rdy_push);
    repeat (3) cyc(1'b0, ad, 1'b0, 1'b0);
    cyc(1'b1, ad, 1'b0, 1'b0);
    cyc(1'b1, ad, 1'b0, 1'b0);
    cyc(1'b1, ad, rdy_push, 1'b0);
  endtask

  logic [23:0] fill [5];

  initial begin
    bit p;
    int len;
    fill[0] = 24'h000000;
    fill[1] = 24'h28A492;
    fill[2] = 24'h514924;
    fill[3] = 24'h79EDB6;
    fill[4] = 24'hA29248;

    reset_n    = 1'b0;
    phi2       = 1'b0;
    d          = 8'h12;
    a          = 16'h3456;
    addr_ready = 1'b0;
    clr_ovf    = 1'b0;
    model_reset();
    model_on   = 1'b1;
    repeat (3) @(negedge fpga);

    check("rst_addr",   {8'h0, addr},        32'h0);
    check("rst_valid",  {31'h0, addr_valid}, 32'h0);
    check("rst_level",  {29'h0, level},      32'h0);
    check("rst_period", {16'h0, period},     32'h0);
    check("rst_ovf",    {31'h0, overflow},   32'h0);
    reset_n = 1'b1;

    // First capture: latency and contents.
    repeat (10) cyc(1'b0, 24'h123456, 1'b0, 1'b0);
    cyc(1'b1, 24'h123456, 1'b0, 1'b0);
    check("lat_k", {31'h0, addr_valid}, 32'h0);
    cyc(1'b1, 24'h123456, 1'b0, 1'b0);
    check("lat_k1", {31'h0, addr_valid}, 32'h0);
    cyc(1'b1, 24'h123456, 1'b0, 1'b0);
    check("lat_k2",     {31'h0, addr_valid}, 32'h1);
    check("first_addr", {8'h0, addr},        32'h123456);
    check("first_lvl",  {29'h0, level},      32'h1);
    check("first_per",  {16'h0, period},     32'd13);

    // Single-cycle low glitch is ignored.
    cyc(1'b1, 24'h0, 1'b0, 1'b0);
    cyc(1'b0, 24'hABCDEF, 1'b0, 1'b0);
    repeat (4) cyc(1'b1, 24'hABCDEF, 1'b0, 1'b0);
    check("glitch_lvl", {29'h0, level},  32'h1);
    check("glitch_per", {16'h0, period}, 32'd13);
    cyc(1'b1, 24'h0, 1'b1, 1'b0);
    check("pop_empty", {29'h0, level}, 32'h0);

    // Fill past capacity.
    for (int i = 0; i < 5; i++) capture(fill[i], 1'b0);
    check("fill_lvl",  {29'h0, level},    32'h4);
    check("fill_ovf",  {31'h0, overflow}, 32'h1);
    check("fill_head", {8'h0, addr},      32'h000000);
    for (int i = 0; i < 4; i++) begin
      check("drain", {8'h0, addr}, {8'h0, fill[i]});
      cyc(1'b1, 24'h0, 1'b1, 1'b0);
    end
    check("drain_valid", {31'h0, addr_valid}, 32'h0);
    cyc(1'b1, 24'h0, 1'b0, 1'b1);
    check("clr_ovf", {31'h0, overflow}, 32'h0);

    // Push and pop together while full.
    for (int i = 0; i < 4; i++) capture(fill[i], 1'b0);
    check("full_lvl", {29'h0, level}, 32'h4);
    capture(fill[4], 1'b1);
    check("pp_lvl",  {29'h0, level},    32'h4);
    check("pp_ovf",  {31'h0, overflow}, 32'h0);
    check("pp_head", {8'h0, addr},      {8'h0, fill[1]});
    repeat (5) cyc(1'b1, 24'h0, 1'b1, 1'b0);

    // Edges 40 cycles apart.
    capture(24'h111111, 1'b1);
    repeat (34) cyc(1'b0, 24'h0, 1'b1, 1'b0);
    capture(24'h222222, 1'b1);
    check("period40", {16'h0, period}, 32'd40);

    // Randomized bus activity.
    p = 1'b1;
    repeat (250) begin
      p   = ~p;
      len = $urandom_range(1, 4);
      repeat (len) cyc(p, 24'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    end
    repeat (6) cyc(1'b1, 24'h0, 1'b1, 1'b1);

    // Saturating period.
    repeat (65600) cyc(1'b0, 24'h0, 1'b1, 1'b0);
    capture(24'h00FFFF, 1'b1);
    check("period_sat", {16'h0, period}, 32'hFFFF);
    repeat (2) cyc(1'b1, 24'h0, 1'b1, 1'b0);

    // Asynchronous reset with a partly full queue and overflow set.
    for (int i = 0; i < 5; i++) capture(fill[i], 1'b0);
    cyc(1'b1, 24'h0, 1'b1, 1'b0);
    check("pre_rst_lvl", {29'h0, level},    32'h3);
    check("pre_rst_ovf", {31'h0, overflow}, 32'h1);
    phi2 = 1'b0;
    addr_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("arst_addr",   {8'h0, addr},        32'h0);
    check("arst_valid",  {31'h0, addr_valid}, 32'h0);
    check("arst_level",  {29'h0, level},      32'h0);
    check("arst_period", {16'h0, period},     32'h0);
    check("arst_ovf",    {31'h0, overflow},   32'h0);
    @(negedge fpga);
    reset_n = 1'b1;
    repeat (2) cyc(1'b0, 24'hABCDEF, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 24'hABCDEF, 1'b0, 1'b0);
    check("post_rst_lvl",  {29'h0, level},  32'h1);
    check("post_rst_addr", {8'h0, addr},    32'hABCDEF);
    check("post_rst_per",  {16'h0, period}, 32'd5);
    repeat (2) cyc(1'b1, 24'h0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
